hamming74_decoder: RTL and testbench

- Receive-side counterpart of the Hamming(7,4) encoder. Accepts a 7-bit codeword, computes the 3-bit syndrome, corrects any single-bit error, and returns the 4-bit data word.
- Two-stage registered pipeline with valid tagging, plus a saturating counter of corrected words.
- Sits between the channel / error-injection logic and the data consumer in the Hamming system.

---
 rtl/hamming74_decoder.sv | 176 +++++++++++++++++
 tb/tb_hamming74_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_decoder.sv
// -----------------------------------------------------------------------------
// hamming74_decoder
//
// Receive-side Hamming(7,4) decoder. A 7-bit codeword is registered together
// with its 3-bit syndrome in stage 1. Stage 2 flips the bit the syndrome points
// at, extracts the 4 data bits and raises valid_out for one cycle. A saturating
// counter tallies the words that needed correction.
//
// Codeword bit order: bit i holds Hamming position i+1
//   [0]=p1 [1]=p2 [2]=d1 [3]=p4 [4]=d2 [5]=d3 [6]=d4
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   EN         in   input-valid strobe, code_in sampled when high
//   code_in    in   received codeword [6:0]
//   clr_count  in   synchronous clear of err_count (wins over an increment)
//   data_out   out  decoded data {d4,d3,d2,d1}
//   code_out   out  corrected codeword, same order as code_in
//   valid_out  out  one-cycle pulse qualifying data_out/code_out/err_flag/err_pos
//   err_flag   out  a single bit was corrected (syndrome non-zero)
//   err_pos    out  syndrome = corrected position 1..7, 0 when clean
//   err_count  out  saturating count of words with err_flag=1
// -----------------------------------------------------------------------------
module hamming74_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [6:0]       code_in,
  input  logic             clr_count,
  output logic [3:0]       data_out,
  output logic [6:0]       code_out,
  output logic             valid_out,
  output logic             err_flag,
  output logic [2:0]       err_pos,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Syndrome {s4,s2,s1}: each bit is the parity over the positions whose
  // index has that bit set, so the value equals the erroneous position.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] code);
    logic s1;
    logic s2;
    logic s4;
    s1 = code[0] ^ code[2] ^ code[4] ^ code[6];
    s2 = code[1] ^ code[2] ^ code[5] ^ code[6];
    s4 = code[3] ^ code[4] ^ code[5] ^ code[6];
    return {s4, s2, s1};
  endfunction

  // Invert the bit at position syn (bit index syn-1); syndrome 0 passes through.
  function automatic logic [6:0] correct_code(input logic [6:0] code,
                                              input logic [2:0] syn);
    logic [6:0] mask;
    mask = 7'b000_0000;
    case (syn)
      3'd1:    mask = 7'b000_0001;
      3'd2:    mask = 7'b000_0010;
      3'd3:    mask = 7'b000_0100;
      3'd4:    mask = 7'b000_1000;
      3'd5:    mask = 7'b001_0000;
      3'd6:    mask = 7'b010_0000;
      3'd7:    mask = 7'b100_0000;
      default: mask = 7'b000_0000;
    endcase
    return code ^ mask;
  endfunction

  // Data bits sit at positions 3,5,6,7.
  function automatic logic [3:0] extract_data(input logic [6:0] code);
    return {code[6], code[5], code[4], code[2]};
  endfunction

  // Stage 1 state
  logic             v1_r;
  logic [6:0]       code1_r;
  logic [2:0]       syn1_r;

  // Stage 2 / output state
  logic [3:0]       data_r;
  logic [6:0]       code_r;
  logic             valid_r;
  logic             flag_r;
  logic [2:0]       pos_r;
  logic [CNT_W-1:0] count_r;

  // Combinational helpers
  logic [6:0]       corr_code_s;
  logic [3:0]       corr_data_s;
  logic             corr_flag_s;
  logic [CNT_W-1:0] count_next_s;

  // Stage 1: capture the codeword and its syndrome on every EN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      code1_r <= 7'b000_0000;
      syn1_r  <= 3'd0;
    end else begin
      v1_r <= EN;
      if (EN) begin
        code1_r <= code_in;
        syn1_r  <= calc_syndrome(code_in);
      end else begin
        code1_r <= code1_r;
        syn1_r  <= syn1_r;
      end
    end
  end

  // Correction datapath feeding stage 2.
  always_comb begin
    corr_code_s = correct_code(code1_r, syn1_r);
    corr_data_s = extract_data(corr_code_s);
    corr_flag_s = (syn1_r != 3'd0);
  end

  // Saturating error counter next value; clear takes priority over increment.
  always_comb begin
    count_next_s = count_r;
    if (clr_count) begin
      count_next_s = CNT_ZERO;
    end else if (v1_r && corr_flag_s && (count_r != CNT_MAX)) begin
      count_next_s = count_r + CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Stage 2: publish the corrected word; outputs hold when no word arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= 4'd0;
      code_r  <= 7'b000_0000;
      flag_r  <= 1'b0;
      pos_r   <= 3'd0;
    end else begin
      valid_r <= v1_r;
      if (v1_r) begin
        data_r <= corr_data_s;
        code_r <= corr_code_s;
        flag_r <= corr_flag_s;
        pos_r  <= syn1_r;
      end else begin
        data_r <= data_r;
        code_r <= code_r;
        flag_r <= flag_r;
        pos_r  <= pos_r;
      end
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign data_out  = data_r;
  assign code_out  = code_r;
  assign valid_out = valid_r;
  assign err_flag  = flag_r;
  assign err_pos   = pos_r;
  assign err_count = count_r;

endmodule

// File: tb/tb_hamming74_decoder.sv
module tb_hamming74_decoder;

  logic       clk;
  logic       rst_n;
  logic       EN;
  logic [6:0] code_in;
  logic       clr_count;

  logic [3:0] data_out;
  logic [6:0] code_out;
  logic       valid_out;
  logic       err_flag;
  logic [2:0] err_pos;
  logic [7:0] err_count;

  logic [3:0] data_out2;
  logic [6:0] code_out2;
  logic       valid_out2;
  logic       err_flag2;
  logic [2:0] err_pos2;
  logic [1:0] err_count2;

  hamming74_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .code_in(code_in), .clr_count(clr_count),
    .data_out(data_out), .code_out(code_out), .valid_out(valid_out),
    .err_flag(err_flag), .err_pos(err_pos), .err_count(err_count)
  );

  hamming74_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .EN(EN), .code_in(code_in), .clr_count(clr_count),
    .data_out(data_out2), .code_out(code_out2), .valid_out(valid_out2),
    .err_flag(err_flag2), .err_pos(err_pos2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] pos;
    logic       flag;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: standard Hamming construction over positions 1..7.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [7:1] w;
    logic par;
    w = '0;
    w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int i = 1; i <= 7; i++) if (((i & p) != 0) && (i != p)) par ^= w[i];
      w[p] = par;
    end
    return w[7:1];
  endfunction

  // Syndrome as the XOR of the indices of all set positions.
  function automatic logic [2:0] syndrome(input logic [6:0] c);
    int s;
    s = 0;
    for (int i = 1; i <= 7; i++) if (c[i-1]) s = s ^ i;
    return 3'(s);
  endfunction

  function automatic exp_t model(input logic [6:0] c, input int due);
    exp_t e;
    logic [6:0] fixed;
    e.due  = due;
    e.pos  = syndrome(c);
    e.flag = (e.pos != 3'd0);
    fixed  = c;
    if (e.flag) fixed[e.pos - 3'd1] = ~fixed[e.pos - 3'd1];
    e.code = fixed;
    e.data = {fixed[6], fixed[5], fixed[4], fixed[2]};
    return e;
  endfunction

  task automatic drive(input logic en, input logic [6:0] code, input logic clr);
    @(posedge clk); #1;
    EN = en; code_in = code; clr_count = clr;
    if (en) q.push_back(model(code, cyc + 2));
  endtask

  function automatic logic [6:0] flip(input logic [6:0] c, input int pos);
    logic [6:0] r;
    r = c;
    if (pos >= 1 && pos <= 7) r[pos-1] = ~r[pos-1];
    return r;
  endfunction

  // Monitor / scoreboard
  logic       prev_clr = 1'b0;
  logic       prev_rst = 1'b0;
  int         exp_cnt8 = 0;
  int         exp_cnt2 = 0;
  logic [3:0] last_data = '0;
  logic [6:0] last_code = '0;
  logic       last_flag = 1'b0;
  logic [2:0] last_pos  = '0;

  always @(negedge clk) begin
    logic ev;
    exp_t e;
    if (!rst_n || !prev_rst) begin
      exp_cnt8 = 0; exp_cnt2 = 0;
      last_data = '0; last_code = '0; last_flag = 1'b0; last_pos = '0;
      ev = 1'b0;
    end else begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) begin
        e = q.pop_front();
        last_data = e.data; last_code = e.code; last_flag = e.flag; last_pos = e.pos;
      end
      if (prev_clr) begin
        exp_cnt8 = 0; exp_cnt2 = 0;
      end else if (ev && e.flag) begin
        if (exp_cnt8 < 255) exp_cnt8++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end
    chk("valid_out", 32'(valid_out), 32'(ev));
    chk("valid_out_sat", 32'(valid_out2), 32'(ev));
    chk("data_out", 32'(data_out), 32'(last_data));
    chk("code_out", 32'(code_out), 32'(last_code));
    chk("err_flag", 32'(err_flag), 32'(last_flag));
    chk("err_pos", 32'(err_pos), 32'(last_pos));
    chk("err_count", 32'(err_count), 32'(exp_cnt8));
    chk("err_count_sat", 32'(err_count2), 32'(exp_cnt2));
    chk("data_out_sat", 32'(data_out2), 32'(last_data));
    if (q.size() > 0 && q[0].due < cyc) begin
      chk("missed_valid", 32'(q[0].due), 32'(cyc));
      void'(q.pop_front());
    end
    prev_clr = clr_count;
    prev_rst = rst_n;
  end

  initial begin
    rst_n = 1'b0; EN = 1'b0; code_in = '0; clr_count = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 7'd0, 0);

    // Clean word and single error
    drive(1, 7'b1010101, 0);
    drive(0, 7'd0, 0);
    drive(0, 7'd0, 0);
    drive(0, 7'd0, 0);
    chk("clean_data", 32'(data_out), 32'h0000000b);
    drive(1, 7'b1000101, 0);
    drive(0, 7'd0, 0);
    drive(0, 7'd0, 0);
    chk("single_pos", 32'(err_pos), 32'd5);
    chk("single_code", 32'(code_out), 32'h00000055);
    chk("single_count", 32'(err_count), 32'd1);

    // Sweep all data x error positions back to back
    drive(0, 7'd0, 1);
    for (int d = 0; d < 16; d++)
      for (int p = 0; p < 8; p++)
        drive(1, flip(encode(4'(d)), p), 0);
    repeat (3) drive(0, 7'd0, 0);
    chk("sweep_count", 32'(err_count), 32'd112);

    // Saturation on the 2-bit counter, then clear coinciding with an increment
    drive(0, 7'd0, 1);
    for (int k = 0; k < 5; k++) drive(1, flip(encode(4'(k)), k + 1), 0);
    repeat (3) drive(0, 7'd0, 0);
    chk("sat_count", 32'(err_count2), 32'd3);
    drive(1, flip(encode(4'd9), 7), 0);
    drive(0, 7'd0, 1);
    drive(0, 7'd0, 0);
    chk("clr_wins_sat", 32'(err_count2), 32'd0);
    chk("clr_wins", 32'(err_count), 32'd0);

    // EN gating: code_in moves, outputs must hold
    for (int k = 0; k < 6; k++) drive(0, 7'($urandom_range(0, 127)), 0);

    // Reset mid-stream
    drive(1, flip(encode(4'd6), 2), 0);
    @(posedge clk); #1;
    EN = 1'b0; rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, flip(encode(4'd12), 4), 0);
    repeat (3) drive(0, 7'd0, 0);

    // Randomized traffic with 0, 1 or 2 bit errors
    for (int k = 0; k < 300; k++) begin
      logic [6:0] c;
      int n, p1, p2;
      c  = encode(4'($urandom_range(0, 15)));
      n  = $urandom_range(0, 2);
      p1 = $urandom_range(1, 7);
      p2 = (p1 % 7) + 1;
      if (n >= 1) c = flip(c, p1);
      if (n == 2) c = flip(c, p2);
      drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 15) == 0);
    end

    repeat (4) drive(0, 7'd0, 0);
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
